wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Sits directly downstream of the functional-unit cluster.
- Accepts one result per cycle from each of NR_IN FU write-back ports, buffers each port in a small FIFO, and round-robin arbitrates the heads onto NR_OUT register-file write ports.
- Each granted output also drives a matching completion port toward the ROB.
- Converts the current one-port-per-FU scheme into a shared, backpressured write-back path; stall flags go upstream to issue.

Parameters:
- NR_IN, 5, number of FU result input ports (ALU, CSR, LSU, DIV, MUL order).
- NR_OUT, 2, number of register-file write ports / completion ports driven.
- DEPTH, 4, entries per input FIFO (power of two, >= 2).
- STALL_MARGIN, 2, free entries reserved for results already in flight inside an FU.

Ports:
- clk  input  1  core clock.
- rstn  input  1  synchronous active-low reset, sampled on rising clk.
- fuoutput_i[NR_IN]  input  fu_output_t  FU results.
- fuoutput_i_valid  input  NR_IN  per-port result valid; no ready returned.
- fu_stall_o  output  NR_IN  issue must not dispatch to that FU while set.
- squash_i  input  1  flush all buffered results.
- wb_o[NR_OUT]  output  fu_output_t  register-file write data.
- wb_o_valid  output  NR_OUT  write enable per port.
- completion_ports_o[NR_OUT]  output  completion_port_t  id = wb_o[k].id, valid = wb_o_valid[k].
- overflow_o  output  1  sticky error: push into a full FIFO.

Behaviour:
- Reset (rstn=0 at posedge): all FIFOs emptied, rr_ptr=0, overflow_o=0. wb_o_valid, completion valids and fu_stall_o read 0 while FIFOs are empty. wb_o data is don't-care when its valid is 0.
- Push: fuoutput_i_valid[i]=1 writes fuoutput_i[i] into FIFO i at the posedge.
- Pop: combinational selection from FIFO heads; the popped entry is removed at the same posedge.
- Latency: a result pushed in cycle N is eligible in cycle N+1, so minimum write-back latency is 1 cycle.
- Arbitration:
  - Scan inputs i = rr_ptr, rr_ptr+1, … modulo NR_IN.
  - Grant up to NR_OUT non-empty FIFOs, one entry per FIFO per cycle.
  - The k-th grant goes to output k.
  - If any grant is made, rr_ptr <= (last granted index + 1) mod NR_IN; otherwise rr_ptr holds.
- Stall: fu_stall_o[i] = (count_i >= DEPTH - STALL_MARGIN), computed from registered count.
- Full with simultaneous pop and push: accepted (count unchanged).
- Full with push and no pop: entry dropped, overflow_o <= 1 until reset. This is a design error; the bench asserts it never fires.
- Squash:
  - squash_i=1 empties every FIFO at the posedge.
  - A push in the same cycle is dropped.
  - Outputs in the squash cycle are still driven from current heads; the ROB discards them by id.
  - rr_ptr is unchanged.
- Wrap-around: read/write pointers are log2(DEPTH)+1 bits. Empty is ptr equal; full is MSB differing with remaining bits equal.
- Reset mid-operation: buffered results are lost; no output valid in the cycle after reset.

Optional Feature:
- Macro: WB_ARB_BYPASS_EN.
- Defined:
  - A FIFO that is empty, not squashed, and receives a push may present the incoming result directly as its head in the same cycle (0-cycle latency).
  - If granted, the entry is not written.
  - If not granted, it is written normally.
- Undefined: minimum latency is 1 cycle as above; no input-to-output combinational path.

Decomposition:
- Package C gets: WB_ARB_NR_OUT, WB_ARB_DEPTH, WB_ARB_STALL_MARGIN, and wb_arb_ptr_t. fu_output_t and completion_port_t are reused unchanged.
- One sub-module, wb_fifo: single-clock FIFO with push, pop, flush, count, head, full and empty, instantiated NR_IN times.
- Round-robin grant logic stays in wb_arbiter.

Test Plan:
- Single result: ALU port pushes id=7 at cycle 10 → wb_o_valid[0]=1, completion id=7 at cycle 11; wb_o_valid[1]=0; rr_ptr=1.
- Three simultaneous results: ports 0,2,4 push ids 1,2,3 at cycle 5 with rr_ptr=0 → cycle 6 outputs ids 1,2; cycle 7 outputs id 3 on output 0.
- Fairness under saturation: all 5 ports push every cycle for 20 cycles with DEPTH=4 and stall honoured → each port granted 8±1 times in 20 cycles; overflow_o stays 0.
- Stall: 2 pushes to port 3 with no drain (other ports always winning) → fu_stall_o[3]=1 next cycle; clears once count drops to 1.
- Squash: 3 entries buffered, squash_i=1 plus a push on port 1 the same cycle → next cycle all wb_o_valid=0 and counts=0.
- Overflow and reset: force 5 pushes into port 0 with no pops → overflow_o=1; rstn=0 for one cycle → overflow_o=0 and all FIFOs empty.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types and defaults for the write-back arbiter (wb_arbiter, wb_fifo).
// Optional zero-latency FIFO bypass is enabled by defining WB_ARB_BYPASS_EN.
package wb_arbiter_pkg;

  localparam int unsigned WB_ARB_NR_IN        = 5;
  localparam int unsigned WB_ARB_NR_OUT       = 2;
  localparam int unsigned WB_ARB_DEPTH        = 4;
  localparam int unsigned WB_ARB_STALL_MARGIN = 2;
  localparam int unsigned WB_ARB_PTR_W        = $clog2(WB_ARB_DEPTH) + 1;

  localparam int unsigned TRANS_ID_BITS = 8;
  localparam int unsigned XLEN          = 32;

  typedef logic [WB_ARB_PTR_W-1:0] wb_arb_ptr_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [XLEN-1:0]          result;
  } fu_output_t;

  typedef struct packed {
    logic                     valid;
    logic [TRANS_ID_BITS-1:0] id;
  } completion_port_t;

endpackage

// File: rtl/wb_fifo.sv
// Single-clock result FIFO with push, pop, flush, count, head, full and empty.
// With WB_ARB_BYPASS_EN defined, an empty FIFO presents an incoming push as its head.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = WB_ARB_DEPTH,
  localparam int unsigned AddrW = $clog2(DEPTH),
  localparam int unsigned PtrW  = AddrW + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push_i,
  input  fu_output_t      data_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output fu_output_t      head_o,
  output logic [PtrW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  fu_output_t      mem_q [DEPTH];
  logic            ptr_empty;
  logic            bypass;
  logic            do_write;

  assign ptr_empty = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                     (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign count_o   = wptr_q - rptr_q;

`ifdef WB_ARB_BYPASS_EN
  assign bypass = ptr_empty & push_i & ~flush_i;
  assign head_o = bypass ? data_i : mem_q[rptr_q[AddrW-1:0]];
`else
  assign bypass = 1'b0;
  assign head_o = mem_q[rptr_q[AddrW-1:0]];
`endif

  // empty_o means "no head to offer", so a bypassed push counts as present.
  assign empty_o = ptr_empty & ~bypass;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    do_write = 1'b0;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else if (!(bypass && pop_i)) begin
      if (pop_i && !ptr_empty) begin
        rptr_d = rptr_q + 1'b1;
      end
      if (push_i && (!full_o || pop_i)) begin
        do_write = 1'b1;
        wptr_d   = wptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wptr_q[AddrW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Buffers FU results per port and round-robin arbitrates them onto the write-back ports.
// Define WB_ARB_BYPASS_EN to allow 0-cycle latency through empty FIFOs.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NR_IN        = WB_ARB_NR_IN,
  parameter int unsigned NR_OUT       = WB_ARB_NR_OUT,
  parameter int unsigned DEPTH        = WB_ARB_DEPTH,
  parameter int unsigned STALL_MARGIN = WB_ARB_STALL_MARGIN
) (
  input  logic              clk,
  input  logic              rstn,
  input  fu_output_t        fuoutput_i [NR_IN],
  input  logic [NR_IN-1:0]  fuoutput_i_valid,
  output logic [NR_IN-1:0]  fu_stall_o,
  input  logic              squash_i,
  output fu_output_t        wb_o [NR_OUT],
  output logic [NR_OUT-1:0] wb_o_valid,
  output completion_port_t  completion_ports_o [NR_OUT],
  output logic              overflow_o
);

  localparam int unsigned IdxW = $clog2(NR_IN);
  localparam int unsigned PtrW = $clog2(DEPTH) + 1;
  localparam logic [PtrW-1:0] StallThr = PtrW'(DEPTH - STALL_MARGIN);

  fu_output_t       head  [NR_IN];
  logic [PtrW-1:0]  count [NR_IN];
  logic [NR_IN-1:0] full, empty, grant;
  logic [IdxW-1:0]  sel   [NR_OUT];
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic             overflow_q, overflow_d;
  int unsigned      n_grant, scan_idx;

  for (genvar i = 0; i < NR_IN; i++) begin : g_fifo
    wb_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (fuoutput_i_valid[i]),
      .data_i  (fuoutput_i[i]),
      .pop_i   (grant[i]),
      .flush_i (squash_i),
      .head_o  (head[i]),
      .count_o (count[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
    assign fu_stall_o[i] = (count[i] >= StallThr);
  end

  // Scan from rr_ptr and hand the k-th non-empty FIFO to output k.
  always_comb begin
    grant      = '0;
    wb_o_valid = '0;
    n_grant    = 0;
    scan_idx   = 0;
    rr_ptr_d   = rr_ptr_q;
    for (int k = 0; k < NR_OUT; k++) begin
      sel[k] = '0;
    end
    for (int unsigned j = 0; j < NR_IN; j++) begin
      scan_idx = 32'(rr_ptr_q) + j;
      if (scan_idx >= NR_IN) begin
        scan_idx = scan_idx - NR_IN;
      end
      if (!empty[scan_idx] && (n_grant < NR_OUT)) begin
        grant[scan_idx]     = 1'b1;
        sel[n_grant]        = IdxW'(scan_idx);
        wb_o_valid[n_grant] = 1'b1;
        n_grant             = n_grant + 1;
        rr_ptr_d = (scan_idx == NR_IN - 1) ? '0 : IdxW'(scan_idx + 1);
      end
    end
    // Squashed grants are discarded downstream, so they do not advance fairness.
    if (squash_i) begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  for (genvar k = 0; k < NR_OUT; k++) begin : g_out
    assign wb_o[k] = head[sel[k]];
    assign completion_ports_o[k] = '{valid: wb_o_valid[k], id: wb_o[k].id};
  end

  always_comb begin
    overflow_d = overflow_q;
    if (!squash_i && |(fuoutput_i_valid & full & ~grant)) begin
      overflow_d = 1'b1;
    end
  end

  assign overflow_o = overflow_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (default build, bypass disabled).
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic             clk = 1'b0;
  logic             rstn;
  fu_output_t       fu_in [5];
  logic [4:0]       fu_vld;
  logic [4:0]       stall;
  logic             squash;
  fu_output_t       wb [2];
  logic [1:0]       wb_vld;
  completion_port_t cp [2];
  logic             ovf;

  int total = 0;
  int bad   = 0;
  int grants [5];

  always #5 clk = ~clk;

  wb_arbiter #(
    .NR_IN        (5),
    .NR_OUT       (2),
    .DEPTH        (4),
    .STALL_MARGIN (2)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .fuoutput_i         (fu_in),
    .fuoutput_i_valid   (fu_vld),
    .fu_stall_o         (stall),
    .squash_i           (squash),
    .wb_o               (wb),
    .wb_o_valid         (wb_vld),
    .completion_ports_o (cp),
    .overflow_o         (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    fu_vld = '0;
    squash = 1'b0;
  endtask

  task automatic push(input int p, input logic [7:0] id);
    fu_in[p].id     = id;
    fu_in[p].result = {24'hA5A5A5, id};
    fu_vld[p]       = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] v,
                         input logic [7:0] id0, input logic [7:0] id1);
    chk({tag, "_vld"}, 32'(wb_vld), 32'(v));
    chk({tag, "_cvld"}, {30'b0, cp[1].valid, cp[0].valid}, 32'(v));
    if (v[0]) begin
      chk({tag, "_id0"}, 32'(wb[0].id), 32'(id0));
      chk({tag, "_cid0"}, 32'(cp[0].id), 32'(id0));
      chk({tag, "_dat0"}, wb[0].result, {24'hA5A5A5, id0});
    end
    if (v[1]) begin
      chk({tag, "_id1"}, 32'(wb[1].id), 32'(id1));
      chk({tag, "_cid1"}, 32'(cp[1].id), 32'(id1));
      chk({tag, "_dat1"}, wb[1].result, {24'hA5A5A5, id1});
    end
  endtask

  initial begin
    for (int p = 0; p < 5; p++) begin
      fu_in[p] = '0;
      grants[p] = 0;
    end
    clr_in();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    chk("rst_vld", 32'(wb_vld), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_cvld", {30'b0, cp[1].valid, cp[0].valid}, 32'h0);

    // Single result, 1-cycle latency; rr_ptr -> 1.
    push(0, 8'd7);
    tick(); clr_in();
    chk_out("single", 2'b01, 8'd7, 8'd0);
    tick();
    chk_out("single_idle", 2'b00, 8'd0, 8'd0);

    // Port 4 alone; rr_ptr wraps to 0.
    push(4, 8'd9);
    tick(); clr_in();
    chk_out("p4", 2'b01, 8'd9, 8'd0);

    // Ports 0,2,4 with rr_ptr=0: ids 1,2 then 3.
    push(0, 8'd1); push(2, 8'd2); push(4, 8'd3);
    tick(); clr_in();
    chk_out("three_a", 2'b11, 8'd1, 8'd2);
    tick();
    chk_out("three_b", 2'b01, 8'd3, 8'd0);
    tick();
    chk_out("three_idle", 2'b00, 8'd0, 8'd0);

    // rr_ptr=0: ports 1 and 3 land on outputs 0 and 1; rr_ptr -> 4.
    push(1, 8'd5); push(3, 8'd4);
    tick(); clr_in();
    chk_out("p13", 2'b11, 8'd5, 8'd4);
    tick();
    chk_out("p13_idle", 2'b00, 8'd0, 8'd0);

    // Stall on port 3 while ports 0/1 win.
    push(0, 8'd10); push(1, 8'd11); push(3, 8'd12);
    tick(); clr_in();
    chk("stall_pre", 32'(stall), 32'h0);
    chk_out("stall_a", 2'b11, 8'd10, 8'd11);
    push(0, 8'd13); push(1, 8'd14); push(3, 8'd15);
    tick(); clr_in();
    chk("stall_set", 32'(stall), 32'h08);
    chk_out("stall_b", 2'b11, 8'd12, 8'd13);
    tick();
    chk("stall_clr", 32'(stall), 32'h0);
    chk_out("stall_c", 2'b11, 8'd14, 8'd15);
    tick();
    chk_out("stall_idle", 2'b00, 8'd0, 8'd0);

    // Squash with a same-cycle push; rr_ptr stays at 4.
    push(0, 8'd20); push(2, 8'd21); push(4, 8'd22);
    tick(); clr_in();
    chk_out("sq_pre", 2'b11, 8'd22, 8'd20);
    squash = 1'b1;
    push(1, 8'd23);
    tick(); clr_in();
    chk_out("sq_post", 2'b00, 8'd0, 8'd0);
    chk("sq_stall", 32'(stall), 32'h0);
    push(0, 8'd24); push(4, 8'd25);
    tick(); clr_in();
    chk_out("sq_rr", 2'b11, 8'd25, 8'd24);
    tick();
    chk_out("sq_idle", 2'b00, 8'd0, 8'd0);

    // Saturation with stall honoured: 20 output cycles, 2 grants each.
    for (int c = 0; c < 20; c++) begin
      for (int p = 0; p < 5; p++) begin
        if (!stall[p]) push(p, {4'(p), 4'(c)});
      end
      tick(); clr_in();
      for (int k = 0; k < 2; k++) begin
        if (wb_vld[k]) grants[wb[k].id[7:4]]++;
      end
    end
    for (int p = 0; p < 5; p++) begin
      chk($sformatf("fair_p%0d_cnt%0d", p, grants[p]),
          32'(grants[p] >= 7 && grants[p] <= 9), 32'h1);
    end
    chk("sat_ovf", 32'(ovf), 32'h0);
    squash = 1'b1;
    tick(); clr_in();
    chk_out("sat_flush", 2'b00, 8'd0, 8'd0);

    // Overflow by ignoring stall, then reset clears it.
    for (int c = 0; c < 12; c++) begin
      for (int p = 0; p < 5; p++) push(p, 8'hE0 + 8'(c));
      tick();
    end
    clr_in();
    chk("ovf_set", 32'(ovf), 32'h1);
    chk("ovf_stall", 32'(stall), 32'h1f);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("ovf_rst", 32'(ovf), 32'h0);
    chk("ovf_rst_stall", 32'(stall), 32'h0);
    chk_out("ovf_rst_out", 2'b00, 8'd0, 8'd0);
    push(2, 8'h30);
    tick(); clr_in();
    chk_out("post_rst", 2'b01, 8'h30, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
